// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions: opcode/funct codes, the NOP word, fetch FSM
// encoding and small PC helpers used by the fetch stage.
package mips_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;

   // sll $0,$0,0 -- the canonical pipeline bubble
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'h0000_0004;

   // FETCH: normal operation. DROP: a redirect orphaned an in-flight
   // request; its data must be swallowed when it finally returns.
   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_DROP  = 1'b1
   } fetch_state_e;

   // Clear the byte-offset bits so the PC always names a whole word.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/ready port. The fetch stage is the master.
interface instr_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds it on stall and
// replaces it with a NOP bubble on flush or when nothing is available.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        hold,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic [31:0] instr_o
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] instr_q, instr_d;

   // Next-state selection: flush beats hold, hold beats load, else bubble.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      if (flush) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (hold) begin
         valid_d = valid_q;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = load_pc;
         pc4_d   = load_pc + PC_STEP;
         instr_d = load_instr;
      end else begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   // IF/ID state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0004;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS-32 fetch stage: PC, fetch FSM, one-entry hold buffer for words that
// arrive during a stall, and the IF/ID register with decoded field slices.
module instr_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   instr_fetch_stage_if.master        imem,
   output logic                       id_valid,
   output logic [31:0]                id_pc,
   output logic [31:0]                id_pc4,
   output logic [31:0]                id_instr,
   output logic [5:0]                 id_opcode,
   output logic [4:0]                 id_rs,
   output logic [4:0]                 id_rt,
   output logic [4:0]                 id_rd,
   output logic [4:0]                 id_shamt,
   output logic [5:0]                 id_funct,
   output logic [15:0]                id_imm16,
   output logic [25:0]                id_target
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;
   logic         req_q, req_d;
   logic         buf_valid_q, buf_valid_d;
   logic [31:0]  buf_pc_q, buf_pc_d;
   logic [31:0]  buf_instr_q, buf_instr_d;

   logic         complete_s;
   logic         pending_s;
   logic         flush_s;
   logic         ifid_hold_s;
   logic         ifid_load_s;
   logic [31:0]  ifid_pc_s;
   logic [31:0]  ifid_instr_s;

   assign complete_s = req_q & imem.ready;
   assign pending_s  = req_q & ~imem.ready;

   // Fetch FSM, PC update, hold buffer and IF/ID steering.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_valid_d  = buf_valid_q;
      buf_pc_d     = buf_pc_q;
      buf_instr_d  = buf_instr_q;
      flush_s      = 1'b0;
      ifid_hold_s  = 1'b0;
      ifid_load_s  = 1'b0;
      ifid_pc_s    = buf_pc_q;
      ifid_instr_s = buf_instr_q;
      if (redirect) begin
         // A word returning this very cycle is simply ignored; one still
         // outstanding must be swallowed later in DROP.
         pc_d        = word_align(redirect_pc);
         buf_valid_d = 1'b0;
         flush_s     = 1'b1;
         state_d     = pending_s ? ST_DROP : ST_FETCH;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (complete_s) begin
                  pc_d = pc_q + PC_STEP;
                  if (stall) begin
                     buf_valid_d = 1'b1;
                     buf_pc_d    = pc_q;
                     buf_instr_d = imem.rdata;
                  end else begin
                     ifid_load_s  = 1'b1;
                     ifid_pc_s    = pc_q;
                     ifid_instr_s = imem.rdata;
                  end
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_DROP: begin
               if (complete_s) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DROP;
               end
            end
            default: state_d = ST_FETCH;
         endcase
         if (stall) begin
            ifid_hold_s = 1'b1;
         end else if (buf_valid_q) begin
            // Buffer and memory are never both live: no request is made
            // while the buffer is full.
            ifid_load_s  = 1'b1;
            ifid_pc_s    = buf_pc_q;
            ifid_instr_s = buf_instr_q;
            buf_valid_d  = 1'b0;
         end else begin
            ifid_hold_s = 1'b0;
         end
      end
      // Request is registered so it cannot rise in the reset-release cycle;
      // the address is frozen for as long as a transaction is open.
      req_d  = (state_d == ST_DROP) | ~buf_valid_d;
      addr_d = pending_s ? addr_q : pc_d;
   end

   // Fetch-side state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         req_q       <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= 32'h0000_0000;
         buf_instr_q <= NOP_INSTR;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
      end
   end

   assign imem.req  = req_q;
   assign imem.addr = addr_q;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_s),
      .hold       (ifid_hold_s),
      .load       (ifid_load_s),
      .load_pc    (ifid_pc_s),
      .load_instr (ifid_instr_s),
      .valid_o    (id_valid),
      .pc_o       (id_pc),
      .pc4_o      (id_pc4),
      .instr_o    (id_instr)
   );

   assign id_opcode = id_instr[31:26];
   assign id_rs     = id_instr[25:21];
   assign id_rt     = id_instr[20:16];
   assign id_rd     = id_instr[15:11];
   assign id_shamt  = id_instr[10:6];
   assign id_funct  = id_instr[5:0];
   assign id_imm16  = id_instr[15:0];
   assign id_target = id_instr[25:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a program-order model predicts
// which words reach IF/ID and when the stage must be requesting.
module tb_instr_fetch_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready;
   logic        id_valid;
   logic [31:0] id_pc, id_pc4, id_instr;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_imm16;
   logic [25:0] id_target;

   instr_fetch_stage_if imem_bus ();

   instr_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem_bus.master),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_pc4      (id_pc4),
      .id_instr    (id_instr),
      .id_opcode   (id_opcode),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_shamt    (id_shamt),
      .id_funct    (id_funct),
      .id_imm16    (id_imm16),
      .id_target   (id_target)
   );

   always #5 clk = ~clk;

   // Memory image: address 0x20 holds lui $1,0x1234, everything else is
   // derived from its own address so a wrong fetch address shows up.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = (a | 32'h0000_000A) ^ {a[9:4], 26'h0};
      if (a == 32'h0000_0020) w = 32'h3C01_1234;
      return w;
   endfunction

   assign imem_bus.ready = ready;
   assign imem_bus.rdata = mem_word(imem_bus.addr);

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   item_t       exp_q[$];
   logic [31:0] fetch_pc = 32'h0;
   bit          drop = 1'b0;

   // Monitor: capture the cycle's inputs at the falling edge, then advance
   // the model at the rising edge and compare DUT outputs 1 ns later.
   initial begin
      logic        c_rst, c_stall, c_redir, c_req, c_ready;
      logic [31:0] c_rpc, c_addr, p_addr;
      bit          p_hold;
      item_t       it;
      bit          comp;
      p_hold = 1'b0;
      p_addr = 32'h0;
      forever begin
         @(negedge clk);
         c_rst = rst; c_stall = stall; c_redir = redirect; c_rpc = redirect_pc;
         c_req = imem_bus.req; c_addr = imem_bus.addr; c_ready = ready;
         if (p_hold) begin
            check32("req_held", {31'h0, c_req}, 32'h1);
            check32("addr_stable", c_addr, p_addr);
         end
         p_hold = c_req && !c_ready && !c_rst;
         p_addr = c_addr;
         @(posedge clk);
         #1;
         if (c_rst) begin
            exp_q.delete();
            fetch_pc = 32'h0;
            drop = 1'b0;
            check32("rst_id_valid", {31'h0, id_valid}, 32'h0);
            check32("rst_id_instr", id_instr, 32'h0);
            check32("rst_id_pc", id_pc, 32'h0);
            check32("rst_id_pc4", id_pc4, 32'h4);
         end else begin
            comp = c_req && c_ready;
            if (c_redir) begin
               exp_q.delete();
               drop = comp ? 1'b0 : c_req;
               fetch_pc = c_rpc & 32'hFFFF_FFFC;
               check32("flush_valid", {31'h0, id_valid}, 32'h0);
               check32("flush_instr", id_instr, 32'h0);
            end else begin
               if (comp) begin
                  if (drop) begin
                     drop = 1'b0;
                  end else begin
                     check32("fetch_addr", c_addr, fetch_pc);
                     exp_q.push_back('{pc: fetch_pc, instr: mem_word(fetch_pc)});
                     fetch_pc = fetch_pc + 32'd4;
                  end
               end
               if (!c_stall) begin
                  if (exp_q.size() > 0) begin
                     it = exp_q.pop_front();
                     delivered++;
                     check32("id_valid", {31'h0, id_valid}, 32'h1);
                     check32("id_pc", id_pc, it.pc);
                     check32("id_pc4", id_pc4, it.pc + 32'd4);
                     check32("id_instr", id_instr, it.instr);
                     check32("id_opcode", {26'h0, id_opcode}, {26'h0, it.instr[31:26]});
                     check32("id_rs", {27'h0, id_rs}, {27'h0, it.instr[25:21]});
                     check32("id_rt", {27'h0, id_rt}, {27'h0, it.instr[20:16]});
                     check32("id_rd", {27'h0, id_rd}, {27'h0, it.instr[15:11]});
                     check32("id_shamt", {27'h0, id_shamt}, {27'h0, it.instr[10:6]});
                     check32("id_funct", {26'h0, id_funct}, {26'h0, it.instr[5:0]});
                     check32("id_imm16", {16'h0, id_imm16}, {16'h0, it.instr[15:0]});
                     check32("id_target", {6'h0, id_target}, {6'h0, it.instr[25:0]});
                  end else begin
                     check32("bubble_valid", {31'h0, id_valid}, 32'h0);
                     check32("bubble_instr", id_instr, 32'h0);
                  end
               end
            end
         end
         // Fetch whenever nothing is waiting, or while an orphan is pending.
         check32("imem_req", {31'h0, imem_bus.req},
                 {31'h0, (!c_rst && (drop || exp_q.size() == 0))});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
      step(2);
      rst = 1'b0;
      step(12);
      // late memory
      ready = 1'b0; step(3);
      ready = 1'b1; step(3);
      // stall while the LUI word arrives
      redirect = 1'b1; redirect_pc = 32'h0000_0020; step(1);
      redirect = 1'b0; stall = 1'b1; step(3);
      stall = 1'b0; step(3);
      // redirect with a request outstanding
      ready = 1'b0; step(1);
      redirect = 1'b1; redirect_pc = 32'h0000_0103; step(1);
      redirect = 1'b0; step(2);
      ready = 1'b1; step(4);
      // PC wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4; step(1);
      redirect = 1'b0; step(6);
      // randomized traffic
      repeat (400) begin
         ready = ($urandom_range(0, 99) < 70);
         stall = ($urandom_range(0, 99) < 20);
         if (!redirect && $urandom_range(0, 99) < 5) begin
            redirect = 1'b1;
            redirect_pc = $urandom;
         end else begin
            redirect = 1'b0;
         end
         step(1);
      end
      // reset with a request outstanding
      redirect = 1'b0; stall = 1'b0; ready = 1'b0; step(2);
      rst = 1'b1; step(1);
      rst = 1'b0; ready = 1'b1; step(6);
      // reset with the hold buffer full
      stall = 1'b1; step(2);
      rst = 1'b1; step(1);
      rst = 1'b0; stall = 1'b0; step(6);
      checks++;
      if (delivered < 60) begin
         errors++;
         $display("FAIL throughput: got %0d instructions expected at least 60", delivered);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
